// File: rtl/button_debouncer_bank_if.sv
// rtl/button_debouncer_bank_if.sv - raw button inputs and conditioned outputs of the debouncer bank
interface button_debouncer_bank_if #(
    parameter int N_BTN = 6
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic             any_level;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  any_level
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release,
        output any_level
    );
endinterface

// File: rtl/button_debouncer_bank.sv
// rtl/button_debouncer_bank.sv - six-channel button synchroniser, debouncer and exclusive-press arbiter
module button_debouncer_bank #(
    parameter int N_BTN           = 6,
    parameter int DEBOUNCE_CYCLES = 328,
    parameter int CNT_W           = 10,
    parameter int EXCLUSIVE       = 1
) (
    input  logic                  clk,
    input  logic                  rst_sync,
    button_debouncer_bank_if.slave bus
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARM    = 3'd1;
    localparam logic [2:0] ST_HELD   = 3'd2;
    localparam logic [2:0] ST_DISARM = 3'd3;
    localparam logic [2:0] ST_LOCKED = 3'd4;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync;
    logic [2:0]       state     [N_BTN];
    logic [2:0]       state_nxt [N_BTN];
    logic [CNT_W-1:0] cnt       [N_BTN];
    logic [CNT_W-1:0] cnt_nxt   [N_BTN];
    logic [N_BTN-1:0] owned;
    logic [N_BTN-1:0] commit;
    logic [N_BTN-1:0] blocked;
    logic [N_BTN-1:0] level_nxt;
    logic [N_BTN-1:0] press_nxt;
    logic [N_BTN-1:0] release_nxt;
    logic [N_BTN-1:0] level_q;
    logic [N_BTN-1:0] press_q;
    logic [N_BTN-1:0] release_q;
    logic             any_q;

    // Two-flop synchroniser on the asynchronous button pins.
    always_ff @(posedge clk or posedge rst_sync) begin
        if (rst_sync) begin
            sync1 <= '0;
            sync  <= '0;
        end else begin
            sync1 <= bus.btn_raw;
            sync  <= sync1;
        end
    end

    // Per-channel ownership (level high) and commit-this-cycle flags feeding the arbiter.
    always_comb begin
        owned  = '0;
        commit = '0;
        for (int i = 0; i < N_BTN; i++) begin
            owned[i]  = (state[i] == ST_HELD) || (state[i] == ST_DISARM);
            commit[i] = (state[i] == ST_ARM) && sync[i] && (cnt[i] == CNT_LAST);
        end
    end

    // A commit loses if another channel already owns the level or a lower index commits now.
    always_comb begin
        blocked = '0;
        for (int i = 0; i < N_BTN; i++) begin
            for (int j = 0; j < N_BTN; j++) begin
                if (EXCLUSIVE != 0) begin
                    if ((j != i) && owned[j]) blocked[i] = 1'b1;
                    if ((j < i) && commit[j]) blocked[i] = 1'b1;
                end
            end
        end
    end

    // Hold-time state machine and counter next-state per channel.
    always_comb begin
        press_nxt   = '0;
        release_nxt = '0;
        level_nxt   = '0;
        for (int i = 0; i < N_BTN; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            case (state[i])
                ST_IDLE: begin
                    if (sync[i]) begin
                        state_nxt[i] = ST_ARM;
                        cnt_nxt[i]   = '0;
                    end
                end
                ST_ARM: begin
                    if (!sync[i]) begin
                        state_nxt[i] = ST_IDLE;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        cnt_nxt[i] = '0;
                        if (blocked[i]) begin
                            state_nxt[i] = ST_LOCKED;
                        end else begin
                            state_nxt[i] = ST_HELD;
                            press_nxt[i] = 1'b1;
                        end
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    if (!sync[i]) begin
                        state_nxt[i] = ST_DISARM;
                        cnt_nxt[i]   = '0;
                    end
                end
                ST_DISARM: begin
                    if (sync[i]) begin
                        state_nxt[i] = ST_HELD;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        state_nxt[i]   = ST_IDLE;
                        cnt_nxt[i]     = '0;
                        release_nxt[i] = 1'b1;
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_W'(1);
                    end
                end
                ST_LOCKED: begin
                    // Rejected press waits out a qualified release silently.
                    if (sync[i]) begin
                        cnt_nxt[i] = '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        state_nxt[i] = ST_IDLE;
                        cnt_nxt[i]   = '0;
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt[i] = ST_IDLE;
                    cnt_nxt[i]   = '0;
                end
            endcase
            level_nxt[i] = (state_nxt[i] == ST_HELD) || (state_nxt[i] == ST_DISARM);
        end
    end

    // State, counters and output registers; outputs move on the same edge as the state.
    always_ff @(posedge clk or posedge rst_sync) begin
        if (rst_sync) begin
            for (int i = 0; i < N_BTN; i++) begin
                state[i] <= ST_IDLE;
                cnt[i]   <= '0;
            end
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            any_q     <= 1'b0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
            level_q   <= level_nxt;
            press_q   <= press_nxt;
            release_q <= release_nxt;
            any_q     <= |level_nxt;
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.any_level   = any_q;
endmodule

// File: tb/tb_button_debouncer_bank.sv
// tb/tb_button_debouncer_bank.sv - directed table-driven bench for button_debouncer_bank
module tb_button_debouncer_bank;
    logic       clk = 1'b0;
    logic       rst_sync = 1'b0;
    logic [5:0] raw = 6'b0;

    always #5 clk = ~clk;

    button_debouncer_bank_if #(.N_BTN(6)) bus_x ();
    button_debouncer_bank_if #(.N_BTN(6)) bus_i ();

    assign bus_x.btn_raw = raw;
    assign bus_i.btn_raw = raw;

    button_debouncer_bank #(
        .N_BTN(6), .DEBOUNCE_CYCLES(4), .CNT_W(10), .EXCLUSIVE(1)
    ) dut_x (
        .clk(clk), .rst_sync(rst_sync), .bus(bus_x)
    );

    button_debouncer_bank #(
        .N_BTN(6), .DEBOUNCE_CYCLES(4), .CNT_W(10), .EXCLUSIVE(0)
    ) dut_i (
        .clk(clk), .rst_sync(rst_sync), .bus(bus_i)
    );

    typedef struct {
        logic [5:0] raw;
        logic [5:0] lvl;
        logic [5:0] prs;
        logic [5:0] rel;
    } vec_t;

    vec_t tbl[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [5:0] acc_prs, acc_rel, acc_lvl_or, acc_lvl_and;
    logic [5:0] acc_prs_i, acc_rel_i;

    function automatic vec_t mk(logic [5:0] r, logic [5:0] l, logic [5:0] p, logic [5:0] e);
        vec_t v;
        v.raw = r;
        v.lvl = l;
        v.prs = p;
        v.rel = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic clr_acc();
        acc_prs     = '0;
        acc_rel     = '0;
        acc_lvl_or  = '0;
        acc_lvl_and = '1;
        acc_prs_i   = '0;
        acc_rel_i   = '0;
    endtask

    task automatic tick(input logic [5:0] r);
        raw = r;
        @(posedge clk);
        #1;
        acc_prs     |= bus_x.btn_press;
        acc_rel     |= bus_x.btn_release;
        acc_lvl_or  |= bus_x.btn_level;
        acc_lvl_and &= bus_x.btn_level;
        acc_prs_i   |= bus_i.btn_press;
        acc_rel_i   |= bus_i.btn_release;
    endtask

    task automatic do_reset();
        raw = '0;
        rst_sync = 1'b1;
        @(posedge clk);
        #1;
        rst_sync = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] bounce;
        bounce = 6'b101101;
        clr_acc();

        // Clean press/release on channel 0: 20 cycles high then low.
        for (int s = 0; s < 30; s++)
            tbl.push_back(mk((s < 20) ? 6'b000001 : 6'b000000,
                             (s >= 6 && s < 26) ? 6'b000001 : 6'b000000,
                             (s == 6) ? 6'b000001 : 6'b000000,
                             (s == 26) ? 6'b000001 : 6'b000000));
        // Bounce on channel 2: samples 1,0,1,1,0,1 then steady high; press 6 edges after last rise.
        for (int s = 0; s < 16; s++)
            tbl.push_back(mk((s >= 6 || bounce[5 - s]) ? 6'b000100 : 6'b000000,
                             (s >= 11) ? 6'b000100 : 6'b000000,
                             (s == 11) ? 6'b000100 : 6'b000000,
                             6'b000000));

        // Reset state.
        raw = '0;
        rst_sync = 1'b1;
        @(posedge clk);
        #1;
        chk("reset level", bus_x.btn_level, 6'b0);
        chk("reset press", bus_x.btn_press, 6'b0);
        chk("reset release", bus_x.btn_release, 6'b0);
        chk("reset any", {5'b0, bus_x.any_level}, 6'b0);
        chk("reset level indep", bus_i.btn_level, 6'b0);
        rst_sync = 1'b0;

        foreach (tbl[k]) begin
            tick(tbl[k].raw);
            chk($sformatf("vec%0d level", k), bus_x.btn_level, tbl[k].lvl);
            chk($sformatf("vec%0d press", k), bus_x.btn_press, tbl[k].prs);
            chk($sformatf("vec%0d release", k), bus_x.btn_release, tbl[k].rel);
            chk($sformatf("vec%0d any", k), {5'b0, bus_x.any_level}, {5'b0, |tbl[k].lvl});
        end

        // Simultaneous commit of channels 4 and 5: lowest index wins.
        do_reset();
        clr_acc();
        repeat (6) tick(6'b110000);
        chk("simul pre level", bus_x.btn_level, 6'b000000);
        tick(6'b110000);
        chk("simul level", bus_x.btn_level, 6'b010000);
        chk("simul press", bus_x.btn_press, 6'b010000);
        chk("simul any", {5'b0, bus_x.any_level}, 6'b000001);
        chk("simul indep level", bus_i.btn_level, 6'b110000);
        tick(6'b110000);
        chk("simul press gone", bus_x.btn_press, 6'b000000);
        repeat (3) tick(6'b110000);
        clr_acc();
        repeat (8) tick(6'b000000);
        chk("simul release", acc_rel, 6'b010000);
        chk("simul no press", acc_prs, 6'b000000);
        chk("simul end level", bus_x.btn_level, 6'b000000);

        // Exclusive lockout: channel 1 held, channel 3 pressed and released.
        do_reset();
        clr_acc();
        repeat (8) tick(6'b000010);
        chk("lock hold level", bus_x.btn_level, 6'b000010);
        clr_acc();
        repeat (10) tick(6'b001010);
        repeat (10) tick(6'b000010);
        chk("lock level seen", acc_lvl_or, 6'b000010);
        chk("lock no press", acc_prs, 6'b000000);
        chk("lock no release", acc_rel, 6'b000000);
        chk("indep press", acc_prs_i, 6'b001000);
        chk("indep release", acc_rel_i, 6'b001000);
        repeat (8) tick(6'b000000);
        repeat (8) tick(6'b001000);
        chk("lock recovered", bus_x.btn_level, 6'b001000);

        // Reset while channel 5 is held.
        do_reset();
        clr_acc();
        repeat (8) tick(6'b100000);
        chk("rst hold level", bus_x.btn_level, 6'b100000);
        #2;
        rst_sync = 1'b1;
        #1;
        chk("rst immediate level", bus_x.btn_level, 6'b000000);
        chk("rst immediate any", {5'b0, bus_x.any_level}, 6'b000000);
        chk("rst immediate release", bus_x.btn_release, 6'b000000);
        @(posedge clk);
        #1;
        rst_sync = 1'b0;
        clr_acc();
        repeat (6) tick(6'b100000);
        chk("rst no early press", acc_prs, 6'b000000);
        tick(6'b100000);
        chk("rst re-press", bus_x.btn_press, 6'b100000);
        chk("rst no release", acc_rel, 6'b000000);

        // Two-cycle glitch low while channel 0 held.
        do_reset();
        repeat (8) tick(6'b000001);
        clr_acc();
        repeat (2) tick(6'b000000);
        repeat (10) tick(6'b000001);
        chk("glitch level held", acc_lvl_and, 6'b000001);
        chk("glitch no release", acc_rel, 6'b000000);
        chk("glitch no press", acc_prs, 6'b000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
